// File: rtl/ofdm_pkg.sv
`default_nettype none
//============================================================================
// Module   : ofdm_pkg
// Brief    : Shared types and constants for the OFDM receive-path stages
// Revision : 1.0 - initial release
//============================================================================
package ofdm_pkg;

    // Stripper sequencing states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PREFIX = 2'd1,
        BODY   = 2'd2,
        DRAIN  = 2'd3
    } state_e;

    // Avalon-ST error bus codes, meaningful only on the eop beat
    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_SHORT = 2'b01;
    localparam logic [1:0] ERR_LONG  = 2'b10;

    // Ceiling log2 for counter sizing; clog2(1) = 0
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/avst_out_reg.sv
`default_nettype none
//============================================================================
// Module   : avst_out_reg
// Brief    : One-deep Avalon-ST output register with upstream ready
// Revision : 1.0 - initial release
//============================================================================
module avst_out_reg
    import ofdm_pkg::*;
#(
    parameter int W = 29
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         sop_i,
    input  logic         eop_i,
    input  logic [1:0]   err_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic         sop_o,
    output logic         eop_o,
    output logic [1:0]   err_o,
    output logic         in_ready_o
);

    logic         valid_q;
    logic [W-1:0] data_q;
    logic         sop_q;
    logic         eop_q;
    logic [1:0]   err_q;

    // Upstream may push whenever the slot is empty or is being drained this cycle
    assign in_ready_o = !valid_q || ready_i;

    // Load a new beat, or retire the held one when the sink takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            err_q   <= ERR_NONE;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            sop_q   <= sop_i;
            eop_q   <= eop_i;
            err_q   <= err_i;
        end else if (ready_i) begin
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            err_q   <= ERR_NONE;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign sop_o   = sop_q;
    assign eop_o   = eop_q;
    assign err_o   = err_q;

endmodule
`default_nettype wire

// File: rtl/ofdm_cp_stripper.sv
`default_nettype none
//============================================================================
// Module   : ofdm_cp_stripper
// Brief    : Removes the cyclic prefix of every OFDM symbol in a packet and
//            reframes the bodies as one output packet, flagging short/long
//            packets on the error bus
// Revision : 1.0 - initial release
//============================================================================
module ofdm_cp_stripper
    import ofdm_pkg::*;
#(
    parameter int CP_LEN       = 256,
    parameter int FFT_LEN      = 1024,
    parameter int SYMS_PER_PKT = 1,
    parameter int IN_W         = 32,
    parameter int OUT_W        = 29
) (
    input  logic             clock_clk,
    input  logic             reset_reset_n,
    input  logic [IN_W-1:0]  asi_in0_data,
    input  logic             asi_in0_valid,
    output logic             asi_in0_ready,
    input  logic             asi_in0_startofpacket,
    input  logic             asi_in0_endofpacket,
    output logic [OUT_W-1:0] aso_out0_data,
    output logic             aso_out0_valid,
    input  logic             aso_out0_ready,
    output logic             aso_out0_startofpacket,
    output logic             aso_out0_endofpacket,
    output logic [1:0]       aso_out0_error,
    output logic             drop_pulse
);

    localparam int SAMP_MAX = (CP_LEN > FFT_LEN) ? CP_LEN : FFT_LEN;
    localparam int SW       = clog2(SAMP_MAX);
    localparam int YW       = clog2(SYMS_PER_PKT) + 1;

    localparam logic [SW-1:0] CP_LAST  = SW'(CP_LEN - 1);
    localparam logic [SW-1:0] FFT_LAST = SW'(FFT_LEN - 1);
    localparam logic [SW-1:0] SAMP_ONE = SW'(1);
    localparam logic [YW-1:0] SYM_LAST = YW'(SYMS_PER_PKT - 1);
    localparam logic [YW-1:0] SYM_ONE  = YW'(1);

    state_e        state_q, state_d;
    logic [SW-1:0] samp_cnt_q, samp_cnt_d;
    logic [YW-1:0] sym_cnt_q, sym_cnt_d;
    logic          started_q, started_d;
    logic          drop_q, drop_d;

    logic             w_acc;
    logic             w_load;
    logic [OUT_W-1:0] w_ld_data;
    logic             w_ld_sop;
    logic             w_ld_eop;
    logic [1:0]       w_ld_err;
    logic             w_last_samp;
    logic             w_last_sym;
    logic             w_unused;

    // Only the top OUT_W bits travel downstream; the truncated LSBs are dropped
    assign w_unused = ^asi_in0_data;

    assign w_acc       = asi_in0_valid && asi_in0_ready;
    assign w_last_samp = (samp_cnt_q == FFT_LAST);
    assign w_last_sym  = (sym_cnt_q == SYM_LAST);

    // Next-state and output-beat decode for each accepted input sample
    always_comb begin
        state_d    = state_q;
        samp_cnt_d = samp_cnt_q;
        sym_cnt_d  = sym_cnt_q;
        started_d  = started_q;
        drop_d     = 1'b0;
        w_load     = 1'b0;
        w_ld_data  = asi_in0_data[IN_W-1 -: OUT_W];
        w_ld_sop   = 1'b0;
        w_ld_eop   = 1'b0;
        w_ld_err   = ERR_NONE;
        if (w_acc) begin
            case (state_q)
                IDLE: begin
                    // Beats outside a packet are ignored until a sop shows up
                    if (asi_in0_startofpacket) begin
                        sym_cnt_d = '0;
                        started_d = 1'b0;
                        if (asi_in0_endofpacket) begin
                            drop_d = 1'b1;
                        end else if (CP_LEN == 1) begin
                            state_d    = BODY;
                            samp_cnt_d = '0;
                        end else begin
                            state_d    = PREFIX;
                            samp_cnt_d = SAMP_ONE;
                        end
                    end
                end
                PREFIX: begin
                    if (asi_in0_endofpacket) begin
                        // Close an already-open output packet with a filler beat
                        state_d = IDLE;
                        if (started_q) begin
                            w_load    = 1'b1;
                            w_ld_data = '0;
                            w_ld_eop  = 1'b1;
                            w_ld_err  = ERR_SHORT;
                        end else begin
                            drop_d = 1'b1;
                        end
                    end else if (samp_cnt_q == CP_LAST) begin
                        state_d    = BODY;
                        samp_cnt_d = '0;
                    end else begin
                        samp_cnt_d = samp_cnt_q + SAMP_ONE;
                    end
                end
                BODY: begin
                    w_load    = 1'b1;
                    w_ld_sop  = !started_q;
                    started_d = 1'b1;
                    if (w_last_samp) begin
                        samp_cnt_d = '0;
                        sym_cnt_d  = sym_cnt_q + SYM_ONE;
                    end else begin
                        samp_cnt_d = samp_cnt_q + SAMP_ONE;
                    end
                    if (asi_in0_endofpacket) begin
                        state_d  = IDLE;
                        w_ld_eop = 1'b1;
                        w_ld_err = (w_last_samp && w_last_sym) ? ERR_NONE : ERR_SHORT;
                    end else if (w_last_samp && w_last_sym) begin
                        // Packet overran: terminate output here, swallow the rest
                        state_d  = DRAIN;
                        w_ld_eop = 1'b1;
                        w_ld_err = ERR_LONG;
                    end else if (w_last_samp) begin
                        state_d = PREFIX;
                    end
                end
                DRAIN: begin
                    if (asi_in0_endofpacket) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Sequencer state, counters and the registered drop pulse
    always_ff @(posedge clock_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q    <= IDLE;
            samp_cnt_q <= '0;
            sym_cnt_q  <= '0;
            started_q  <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            samp_cnt_q <= samp_cnt_d;
            sym_cnt_q  <= sym_cnt_d;
            started_q  <= started_d;
            drop_q     <= drop_d;
        end
    end

    assign drop_pulse = drop_q;

    avst_out_reg #(
        .W (OUT_W)
    ) u_out_reg (
        .clk        (clock_clk),
        .rst_n      (reset_reset_n),
        .load_i     (w_load),
        .data_i     (w_ld_data),
        .sop_i      (w_ld_sop),
        .eop_i      (w_ld_eop),
        .err_i      (w_ld_err),
        .ready_i    (aso_out0_ready),
        .valid_o    (aso_out0_valid),
        .data_o     (aso_out0_data),
        .sop_o      (aso_out0_startofpacket),
        .eop_o      (aso_out0_endofpacket),
        .err_o      (aso_out0_error),
        .in_ready_o (asi_in0_ready)
    );

endmodule
`default_nettype wire

// File: tb/tb_ofdm_cp_stripper.sv
`default_nettype none
//============================================================================
// Module   : tb_ofdm_cp_stripper
// Brief    : Scoreboard bench for the cyclic-prefix stripper (CP=4, FFT=8,
//            two symbols per packet)
// Revision : 1.0 - initial release
//============================================================================
module tb_ofdm_cp_stripper;
    import ofdm_pkg::*;

    localparam int CP   = 4;
    localparam int FFT  = 8;
    localparam int SYMS = 2;
    localparam int IW   = 32;
    localparam int OW   = 29;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [IW-1:0] in_data;
    logic          in_valid, in_ready, in_sop, in_eop;
    logic [OW-1:0] out_data;
    logic          out_valid, out_ready, out_sop, out_eop;
    logic [1:0]    out_err;
    logic          drop;

    always #5 clk = ~clk;

    ofdm_cp_stripper #(
        .CP_LEN       (CP),
        .FFT_LEN      (FFT),
        .SYMS_PER_PKT (SYMS),
        .IN_W         (IW),
        .OUT_W        (OW)
    ) dut (
        .clock_clk              (clk),
        .reset_reset_n          (rst_n),
        .asi_in0_data           (in_data),
        .asi_in0_valid          (in_valid),
        .asi_in0_ready          (in_ready),
        .asi_in0_startofpacket  (in_sop),
        .asi_in0_endofpacket    (in_eop),
        .aso_out0_data          (out_data),
        .aso_out0_valid         (out_valid),
        .aso_out0_ready         (out_ready),
        .aso_out0_startofpacket (out_sop),
        .aso_out0_endofpacket   (out_eop),
        .aso_out0_error         (out_err),
        .drop_pulse             (drop)
    );

    typedef struct packed {
        logic [OW-1:0] d;
        logic          s;
        logic          e;
        logic [1:0]    err;
    } beat_t;

    beat_t exp_q[$];
    int    checks    = 0;
    int    errors    = 0;
    int    drop_seen = 0;
    int    cyc       = 0;
    bit    bp        = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Output sample value for input sample i of packet t (input carries it << 3)
    function automatic logic [OW-1:0] sv(input int t, input int i);
        return OW'((t << 8) | i);
    endfunction

    task automatic push(input logic [OW-1:0] d, input logic s, input logic e, input logic [1:0] err);
        beat_t b;
        b.d = d; b.s = s; b.e = e; b.err = err;
        exp_q.push_back(b);
    endtask

    // Full two-symbol packet: bodies are input samples 4..11 and 16..23
    task automatic exp_nominal(input int t, input logic [1:0] last_err);
        for (int i = 4; i <= 11; i++) push(sv(t, i), i == 4, 1'b0, ERR_NONE);
        for (int i = 16; i <= 22; i++) push(sv(t, i), 1'b0, 1'b0, ERR_NONE);
        push(sv(t, 23), 1'b0, 1'b1, last_err);
    endtask

    // Sink ready: constant 1, or the repeating 1,0,0,1 pattern
    task automatic set_ready();
        cyc++;
        out_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            set_ready();
            in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        end
    endtask

    // Present one beat and hold it until the DUT will accept it on the next edge
    task automatic beat(input logic [IW-1:0] d, input logic s, input logic e);
        int guard;
        guard = 0;
        @(negedge clk);
        set_ready();
        in_valid = 1'b1; in_data = d; in_sop = s; in_eop = e;
        #1;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            set_ready();
            #1;
            guard++;
        end
        if (!in_ready) chk("in_ready_wait", {63'd0, in_ready}, 64'd1);
    endtask

    task automatic send_pkt(input int t, input int n, input int rst_at = -1);
        for (int i = 0; i < n; i++) begin
            if (i == rst_at) begin
                @(negedge clk);
                rst_n = 1'b0;
                in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
                #1;
                chk("rst_mid_outputs", {out_valid, out_sop, out_eop, out_err, drop, out_data},
                    64'd0);
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                #1;
                chk("rst_mid_ready", {63'd0, in_ready}, 64'd1);
                return;
            end
            beat(IW'(sv(t, i)) << (IW - OW), i == 0, i == n - 1);
        end
        idle(1);
    endtask

    // Let the output drain, then confirm nothing is owed and the drop count
    task automatic finish_scn(input string name, input int exp_drop);
        int guard;
        guard = 0;
        idle(3);
        while ((exp_q.size() != 0 || out_valid) && guard < 200) begin
            idle(1);
            guard++;
        end
        chk({name, "_pending"}, 64'(exp_q.size()), 64'd0);
        chk({name, "_drop"}, 64'(drop_seen), 64'(exp_drop));
        exp_q.delete();
        drop_seen = 0;
    endtask

    // Monitor: samples mid-cycle, pops the scoreboard on every transfer
    initial begin : monitor
        beat_t b;
        logic  prev_stall;
        logic [32:0] prev_beat;
        prev_stall = 1'b0;
        prev_beat  = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                prev_stall = 1'b0;
                continue;
            end
            if (drop) drop_seen++;
            if (prev_stall && out_valid)
                chk("stall_hold", 64'({out_data, out_sop, out_eop, out_err}), 64'(prev_beat));
            if (out_valid && !out_ready)
                chk("in_ready_stall", {63'd0, in_ready}, 64'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %0h expected no beat",
                             {out_data, out_sop, out_eop, out_err});
                end else begin
                    b = exp_q.pop_front();
                    chk("out_beat", 64'({out_data, out_sop, out_eop, out_err}), 64'(b));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_beat  = {out_data, out_sop, out_eop, out_err};
        end
    end

    initial begin : stim
        rst_n = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        in_data = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_flags", {60'd0, out_sop, out_eop, out_err}, 64'd0);
        chk("rst_data",  64'(out_data), 64'd0);
        chk("rst_drop",  {63'd0, drop}, 64'd0);
        chk("rst_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Nominal packet, sink always ready
        exp_nominal(1, ERR_NONE);
        send_pkt(1, 24);
        finish_scn("nominal", 0);

        // Same packet under 1,0,0,1 backpressure
        bp = 1'b1;
        exp_nominal(2, ERR_NONE);
        send_pkt(2, 24);
        finish_scn("backpressure", 0);
        bp = 1'b0;

        // Input eop on body sample 10: seven beats, last flagged short
        for (int i = 4; i <= 9; i++) push(sv(3, i), i == 4, 1'b0, ERR_NONE);
        push(sv(3, 10), 1'b0, 1'b1, ERR_SHORT);
        send_pkt(3, 11);
        finish_scn("short_body", 0);

        // Input eop on prefix sample 2 before any output: silent drop
        send_pkt(4, 3);
        finish_scn("short_prefix", 1);

        // Input eop on sample 13 (second prefix): synthetic zero beat closes packet
        for (int i = 4; i <= 11; i++) push(sv(5, i), i == 4, 1'b0, ERR_NONE);
        push('0, 1'b0, 1'b1, ERR_SHORT);
        send_pkt(5, 14);
        finish_scn("short_prefix_started", 0);

        // Stray non-sop beat, then a 30-sample packet, then a normal one
        beat(IW'(sv(6, 99)) << (IW - OW), 1'b0, 1'b0);
        idle(1);
        exp_nominal(6, ERR_LONG);
        send_pkt(6, 30);
        exp_nominal(7, ERR_NONE);
        send_pkt(7, 24);
        finish_scn("long", 0);

        // Reset while sample 10 is due: beats for 4..8 already taken, rest abandoned
        for (int i = 4; i <= 8; i++) push(sv(8, i), i == 4, 1'b0, ERR_NONE);
        send_pkt(8, 30, 10);
        finish_scn("reset_mid", 0);
        exp_nominal(9, ERR_NONE);
        send_pkt(9, 24);
        finish_scn("after_reset", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
